// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART baud timebase
//
// Package contents:
//   BaudCntWidth / BaudFracWidth : default divisor field widths
//   MinDiv                       : smallest usable integer divisor (0 and 1 clamp to it)
//   DefaultBaudDiv               : integer divisor active out of reset
//   baud_div_t                   : {integer, fractional} divisor pair
package uart_pkg;

  localparam int BaudCntWidth   = 16;
  localparam int BaudFracWidth  = 4;
  localparam int MinDiv         = 2;
  localparam int DefaultBaudDiv = 16;

  typedef struct packed {
    logic [BaudCntWidth-1:0]  div_int;
    logic [BaudFracWidth-1:0] div_frac;
  } baud_div_t;

endpackage

// File: rtl/uart_baud_gen_if.sv
// rtl/uart_baud_gen_if.sv - control/status bundle between CSR, shifters and the baud timebase
//
// Signals:
//   i_en, i_sync                    : count enable and synchronous phase restart
//   i_div_int, i_div_frac, i_div_load : divisor request and its capture strobe
//   o_tick, o_half                  : end-of-period and mid-period pulses
//   o_count, o_div_active           : period counter and integer divisor in effect
// Modports: master (CSR/shifter side), slave (uart_baud_gen).
interface uart_baud_gen_if #(
  parameter int CntWidth  = 16,
  parameter int FracWidth = 4
);

  logic                 i_en;
  logic                 i_sync;
  logic [CntWidth-1:0]  i_div_int;
  logic [FracWidth-1:0] i_div_frac;
  logic                 i_div_load;
  logic                 o_tick;
  logic                 o_half;
  logic [CntWidth-1:0]  o_count;
  logic [CntWidth-1:0]  o_div_active;

  modport master (
    output i_en, i_sync, i_div_int, i_div_frac, i_div_load,
    input  o_tick, o_half, o_count, o_div_active
  );

  modport slave (
    input  i_en, i_sync, i_div_int, i_div_frac, i_div_load,
    output o_tick, o_half, o_count, o_div_active
  );

endinterface

// File: rtl/uart_baud_frac_acc.sv
// rtl/uart_baud_frac_acc.sv - fractional phase accumulator producing a one-cycle period stretch
//
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_wrap         : period boundary; accumulate i_frac
//   i_clear        : phase restart; zero accumulator and carry (wins over i_wrap)
//   i_frac         : fractional divisor, units of 1/2^FracWidth
//   o_carry        : lengthens the following period by one cycle
module uart_baud_frac_acc #(
  parameter int FracWidth = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wrap,
  input  logic                 i_clear,
  input  logic [FracWidth-1:0] i_frac,
  output logic                 o_carry
);

  logic [FracWidth-1:0] acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [FracWidth:0]   sum;

  assign sum = {1'b0, acc_q} + {1'b0, i_frac};

  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    if (i_clear) begin
      acc_d   = '0;
      carry_d = 1'b0;
    end else if (i_wrap) begin
      acc_d   = sum[FracWidth-1:0];
      carry_d = sum[FracWidth];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
    end
  end

  assign o_carry = carry_q;

endmodule

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - parametrised baud timebase with fractional divisor and phase restart
//
// Build option: UART_BAUD_FRAC_EN enables the fractional accumulator; without it
// i_div_frac is ignored and every period is exactly max(div, 2) cycles.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : enable/sync, divisor request, tick/half pulses, counter and active divisor
// The interface instance must use the same CntWidth/FracWidth as this module.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CntWidth   = BaudCntWidth,
  parameter int FracWidth  = BaudFracWidth,
  parameter int DefaultDiv = DefaultBaudDiv
) (
  input logic            i_clk,
  input logic            i_rst_n,
  uart_baud_gen_if.slave bus
);

  localparam logic [CntWidth:0]   OneW        = (CntWidth+1)'(1);
  localparam logic [CntWidth-1:0] OneC        = CntWidth'(1);
  localparam logic [CntWidth-1:0] MinDivC     = CntWidth'(MinDiv);
  localparam logic [CntWidth-1:0] DefaultDivC = CntWidth'(DefaultDiv);

  logic [CntWidth-1:0] count_q, count_d;
  logic                tick_q, tick_d;
  logic                half_q, half_d;
  logic [CntWidth-1:0] div_q, div_d;
  logic [CntWidth-1:0] pend_int_q, pend_int_d;
  logic                pend_q, pend_d;

  logic [CntWidth-1:0] eff_div;
  logic [CntWidth:0]   len;
  logic                carry;
  logic                at_last;
  logic                at_half;
  logic                wrap;
  logic                apply_pt;
  logic                apply_now;

  // Period length is compared at CntWidth+1 bits so an all-ones divisor plus
  // a fractional carry cannot overflow.
  assign eff_div = (div_q < MinDivC) ? MinDivC : div_q;
  assign len     = {1'b0, eff_div} + {{CntWidth{1'b0}}, carry};
  assign at_last = ({1'b0, count_q} == (len - OneW));
  assign at_half = ({1'b0, count_q} == ((len >> 1) - OneW));
  assign wrap    = bus.i_en & ~bus.i_sync & at_last;

  // A divisor change is only allowed where no period is in flight from the
  // consumer's point of view: a boundary, a restart, or while stalled. A load
  // on such an edge bypasses the pending register and takes effect at once.
  assign apply_pt  = wrap | bus.i_sync | ~bus.i_en;
  assign apply_now = apply_pt & (bus.i_div_load | pend_q);

`ifdef UART_BAUD_FRAC_EN
  logic [FracWidth-1:0] frac_q, frac_d;
  logic [FracWidth-1:0] pend_frac_q, pend_frac_d;

  always_comb begin
    frac_d      = frac_q;
    pend_frac_d = pend_frac_q;
    if (bus.i_div_load) pend_frac_d = bus.i_div_frac;
    if (apply_now) frac_d = bus.i_div_load ? bus.i_div_frac : pend_frac_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      frac_q      <= '0;
      pend_frac_q <= '0;
    end else begin
      frac_q      <= frac_d;
      pend_frac_q <= pend_frac_d;
    end
  end

  uart_baud_frac_acc #(
    .FracWidth(FracWidth)
  ) u_frac_acc (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_wrap  (wrap),
    .i_clear (bus.i_sync),
    .i_frac  (frac_q),
    .o_carry (carry)
  );
`else
  logic frac_unused;
  assign frac_unused = ^bus.i_div_frac;
  assign carry       = 1'b0;
`endif

  always_comb begin
    count_d    = count_q;
    tick_d     = 1'b0;
    half_d     = 1'b0;
    div_d      = div_q;
    pend_int_d = pend_int_q;
    pend_d     = pend_q;

    if (bus.i_sync) begin
      count_d = '0;
    end else if (bus.i_en) begin
      count_d = at_last ? '0 : (count_q + OneC);
      tick_d  = at_last;
      half_d  = at_half;
    end

    if (bus.i_div_load) begin
      pend_int_d = bus.i_div_int;
      pend_d     = 1'b1;
    end
    if (apply_now) begin
      div_d  = bus.i_div_load ? bus.i_div_int : pend_int_q;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q    <= '0;
      tick_q     <= 1'b0;
      half_q     <= 1'b0;
      div_q      <= DefaultDivC;
      pend_int_q <= '0;
      pend_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      tick_q     <= tick_d;
      half_q     <= half_d;
      div_q      <= div_d;
      pend_int_q <= pend_int_d;
      pend_q     <= pend_d;
    end
  end

  assign bus.o_tick       = tick_q;
  assign bus.o_half       = half_q;
  assign bus.o_count      = count_q;
  assign bus.o_div_active = div_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// tb/tb_uart_baud_gen.sv - directed self-checking bench for uart_baud_gen
module tb_uart_baud_gen;
  import uart_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  uart_baud_gen_if #(.CntWidth(16), .FracWidth(4)) bus ();

  uart_baud_gen #(
    .CntWidth   (16),
    .FracWidth  (4),
    .DefaultDiv (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(input baud_div_t v);
    bus.i_div_int  = v.div_int;
    bus.i_div_frac = v.div_frac;
  endtask

  // Steps until o_tick; len = edges taken (-1 on timeout), half_at = edge of first o_half.
  task automatic run_period(output int len, output int half_at, output bit both);
    len = -1; half_at = -1; both = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (bus.o_half && half_at < 0) half_at = i;
      if (bus.o_tick && bus.o_half) both = 1'b1;
      if (bus.o_tick) begin
        len = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_en = 1'b0; bus.i_sync = 1'b0; bus.i_div_load = 1'b0;
    bus.i_div_int = '0; bus.i_div_frac = '0;
    #23;
    checks++; if (bus.o_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b want=0", bus.o_tick); end
    checks++; if (bus.o_half !== 1'b0) begin errors++; $display("FAIL reset_half got=%b want=0", bus.o_half); end
    checks++; if (bus.o_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", bus.o_count); end
    checks++; if (bus.o_div_active !== 16'd16) begin errors++; $display("FAIL reset_div got=%0d want=16", bus.o_div_active); end
  endtask

  task automatic test_default_periods();
    int len, half_at; bit both;
    step();
    bus.i_en = 1'b1;
    rst_n    = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_period(len, half_at, both);
      checks++; if (len !== 16) begin errors++; $display("FAIL default_len[%0d] got=%0d want=16", p, len); end
      checks++; if (half_at !== 8) begin errors++; $display("FAIL default_half[%0d] got=%0d want=8", p, half_at); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL default_overlap[%0d] got=%b want=0", p, both); end
    end
    checks++; if (bus.o_div_active !== 16'd16) begin errors++; $display("FAIL default_div got=%0d want=16", bus.o_div_active); end
  endtask

  task automatic test_sync();
    int len, half_at; bit both;
    for (int i = 0; i < 40 && bus.o_count != 16'd11; i++) step();
    checks++; if (bus.o_count !== 16'd11) begin errors++; $display("FAIL sync_reach got=%0d want=11", bus.o_count); end
    bus.i_sync = 1'b1;
    step();
    bus.i_sync = 1'b0;
    checks++; if (bus.o_count !== 16'd0) begin errors++; $display("FAIL sync_count got=%0d want=0", bus.o_count); end
    checks++; if (bus.o_tick !== 1'b0) begin errors++; $display("FAIL sync_tick got=%b want=0", bus.o_tick); end
    run_period(len, half_at, both);
    checks++; if (half_at !== 8) begin errors++; $display("FAIL sync_half got=%0d want=8", half_at); end
    checks++; if (len !== 16) begin errors++; $display("FAIL sync_len got=%0d want=16", len); end
  endtask

  task automatic test_div_change();
    int len, half_at; bit both;
    baud_div_t v;
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus.o_count !== 16'd5) begin errors++; $display("FAIL chg_count got=%0d want=5", bus.o_count); end
    v = '{div_int: 16'd4, div_frac: 4'd0};
    set_div(v);
    bus.i_div_load = 1'b1;
    step();
    bus.i_div_load = 1'b0;
    checks++; if (bus.o_div_active !== 16'd16) begin errors++; $display("FAIL chg_div_early got=%0d want=16", bus.o_div_active); end
    run_period(len, half_at, both);
    checks++; if (len !== 10) begin errors++; $display("FAIL chg_remaining got=%0d want=10", len); end
    checks++; if (bus.o_div_active !== 16'd4) begin errors++; $display("FAIL chg_div_wrap got=%0d want=4", bus.o_div_active); end
    for (int p = 0; p < 2; p++) begin
      run_period(len, half_at, both);
      checks++; if (len !== 4) begin errors++; $display("FAIL chg_len[%0d] got=%0d want=4", p, len); end
      checks++; if (half_at !== 2) begin errors++; $display("FAIL chg_half[%0d] got=%0d want=2", p, half_at); end
    end
  endtask

  task automatic test_min_div_hold();
    int len, half_at; bit both;
    baud_div_t v;
    v = '{div_int: 16'd0, div_frac: 4'd0};
    set_div(v);
    bus.i_en = 1'b0; bus.i_div_load = 1'b1;
    step();
    bus.i_div_load = 1'b0; bus.i_en = 1'b1;
    checks++; if (bus.o_div_active !== 16'd0) begin errors++; $display("FAIL min0_div got=%0d want=0", bus.o_div_active); end
    run_period(len, half_at, both);
    checks++; if (len !== 2) begin errors++; $display("FAIL min0_len got=%0d want=2", len); end
    checks++; if (half_at !== 1) begin errors++; $display("FAIL min0_half got=%0d want=1", half_at); end
    v = '{div_int: 16'd1, div_frac: 4'd0};
    set_div(v);
    bus.i_div_load = 1'b1;
    step();
    bus.i_div_load = 1'b0;
    checks++; if (bus.o_half !== 1'b1) begin errors++; $display("FAIL min1_half got=%b want=1", bus.o_half); end
    step();
    checks++; if (bus.o_tick !== 1'b1) begin errors++; $display("FAIL min1_tick got=%b want=1", bus.o_tick); end
    checks++; if (bus.o_div_active !== 16'd1) begin errors++; $display("FAIL min1_div got=%0d want=1", bus.o_div_active); end
    run_period(len, half_at, both);
    checks++; if (len !== 2) begin errors++; $display("FAIL min1_len got=%0d want=2", len); end
    checks++; if (both !== 1'b0) begin errors++; $display("FAIL min1_overlap got=%b want=0", both); end
    step();
    bus.i_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (bus.o_count !== 16'd1) begin errors++; $display("FAIL hold_count[%0d] got=%0d want=1", i, bus.o_count); end
      checks++; if ((bus.o_tick | bus.o_half) !== 1'b0) begin errors++; $display("FAIL hold_pulse[%0d] got=%b%b want=00", i, bus.o_tick, bus.o_half); end
    end
    bus.i_en = 1'b1;
    step();
    checks++; if (bus.o_tick !== 1'b1) begin errors++; $display("FAIL hold_resume got=%b want=1", bus.o_tick); end
  endtask

  task automatic test_frac();
    int len, half_at, sum; bit both;
    int exp_len[5];
    baud_div_t v;
`ifdef UART_BAUD_FRAC_EN
    exp_len = '{10, 10, 11, 10, 11};
`else
    exp_len = '{10, 10, 10, 10, 10};
`endif
    v = '{div_int: 16'd10, div_frac: 4'd8};
    set_div(v);
    bus.i_en = 1'b0; bus.i_sync = 1'b1; bus.i_div_load = 1'b1;
    step();
    bus.i_sync = 1'b0; bus.i_div_load = 1'b0; bus.i_en = 1'b1;
    sum = 0;
    for (int p = 1; p <= 34; p++) begin
      run_period(len, half_at, both);
      if (p <= 5) begin
        checks++; if (len !== exp_len[p-1]) begin errors++; $display("FAIL frac_len[%0d] got=%0d want=%0d", p, len, exp_len[p-1]); end
      end
      if (p == 3) begin
        checks++; if (half_at !== 5) begin errors++; $display("FAIL frac_half got=%0d want=5", half_at); end
      end
      if (p >= 3) sum += len;
    end
`ifdef UART_BAUD_FRAC_EN
    checks++; if (sum !== 336) begin errors++; $display("FAIL frac_total got=%0d want=336", sum); end
`else
    checks++; if (sum !== 320) begin errors++; $display("FAIL frac_total got=%0d want=320", sum); end
`endif
  endtask

  task automatic test_async_reset();
    int len, half_at; bit both;
    for (int i = 0; i < 4; i++) step();
    checks++; if (bus.o_count !== 16'd4) begin errors++; $display("FAIL arst_pre got=%0d want=4", bus.o_count); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.o_count !== 16'd0) begin errors++; $display("FAIL arst_count got=%0d want=0", bus.o_count); end
    checks++; if ((bus.o_tick | bus.o_half) !== 1'b0) begin errors++; $display("FAIL arst_pulse got=%b%b want=00", bus.o_tick, bus.o_half); end
    checks++; if (bus.o_div_active !== 16'd16) begin errors++; $display("FAIL arst_div got=%0d want=16", bus.o_div_active); end
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 3; p++) begin
      run_period(len, half_at, both);
      checks++; if (len !== 16) begin errors++; $display("FAIL arst_len[%0d] got=%0d want=16", p, len); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_default_periods();
    test_sync();
    test_div_change();
    test_min_div_hold();
    test_frac();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
Parametrised baud-rate timebase for UART TX/RX; generalises the fixed 16-bit prescaler.
- Configurable counter width.
- Fractional divisor via a phase accumulator.
- Glitch-free divisor updates, applied only at period boundaries.
- Synchronous phase restart, so RX can align mid-bit sampling to a start-bit edge.
- Sits between the CSR block (divisor source) and the uart_tx/uart_rx shifters (tick/half consumers).

Parameters:
CntWidth, 16, width of integer divisor and period counter
FracWidth, 4, width of fractional divisor and accumulator
DefaultDiv, 16, integer divisor active out of reset (must be >= 2)

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_en  input  1  count enable; counter holds while low
i_sync  input  1  synchronous phase restart pulse
i_div_int  input  CntWidth  requested integer divisor
i_div_frac  input  FracWidth  requested fractional divisor, units of 1/2^FracWidth
i_div_load  input  1  capture i_div_int/i_div_frac as pending divisor
o_tick  output  1  one-cycle pulse at end of each bit period
o_half  output  1  one-cycle pulse at mid-period
o_count  output  CntWidth  current period counter value
o_div_active  output  CntWidth  integer divisor currently in effect

Behaviour:
- Reset (async, i_rst_n=0):
  - counter=0, acc=0, carry_q=0.
  - div_q=DefaultDiv, frac_q=0, pending flag=0.
  - o_tick=0, o_half=0.
- All outputs are registered. o_count=counter; o_div_active=div_q.
- Effective divisor: eff_div = max(div_q, 2). Values 0 and 1 are clamped to 2.
- Period length: len = eff_div + carry_q.
- Enabled edge (i_en=1, i_sync=0):
  - If counter==len-1: counter<=0 (wrap).
  - Otherwise: counter<=counter+1.
- Tick: o_tick<=1 on the edge where the counter wraps; 0 otherwise. With i_en held high after reset, o_tick is high after enabled edges N, 2N, ... (N=DefaultDiv).
- Half: o_half<=1 on the enabled edge where counter==(len>>1)-1.
  - For len=16: after edge 8. For len=2: after edge 1.
  - o_tick and o_half are never high together.
- Fraction accounting, at each wrap:
  - {c,acc}<=acc+frac_q, with FracWidth+1-bit add.
  - carry_q<=c; carry_q lengthens the next period by one cycle.
  - Average period = div + frac/2^FracWidth.
- i_en=0: counter, acc and carry_q hold; o_tick=o_half=0.
- i_sync=1 has priority over i_en:
  - counter<=0, acc<=0, carry_q<=0.
  - o_tick<=0, o_half<=0.
  - Any pending divisor is applied.
  - The first o_half follows (len>>1) enabled edges after the sync edge.
- i_div_load=1: pending<={i_div_int,i_div_frac}, pending flag<=1. A later load overwrites the pending value.
- Pending divisor is applied (div_q/frac_q updated, flag cleared) at the first of:
  - a wrap edge;
  - an i_sync edge;
  - any edge with i_en=0.
  - A new divisor governs the period starting at that edge.
- Load on a wrap edge: the newly loaded value takes effect immediately for the next period.
- Counter arithmetic is CntWidth bits, with no overflow, because counter < len <= 2^CntWidth-1+1. For div_q=2^CntWidth-1 with carry, the compare is done at CntWidth+1 bits.

Optional Feature:
UART_BAUD_FRAC_EN
- Defined: fractional accumulator, carry_q and i_div_frac are functional as above.
- Undefined:
  - acc and carry_q are not instantiated; carry treated as 0.
  - i_div_frac is accepted but ignored; frac_q is not stored.
  - Every period is exactly eff_div cycles.

Decomposition:
- uart_pkg:
  - typedef struct baud_div_t {int, frac}, with widths from package localparams.
  - localparam MinDiv=2.
  - localparam DefaultBaudDiv=16.
- One natural sub-module: uart_baud_frac_acc.
  - Holds acc/carry_q.
  - Inputs: wrap, clear, frac. Output: carry.
  - Instantiated only under UART_BAUD_FRAC_EN.

Test Plan:
1. Reset release, i_en=1, default div 16: o_tick after edges 16, 32, 48; o_half after edges 8, 24; o_div_active=16.
2. FRAC_EN, FracWidth=4, load div=10 frac=8 while i_en=0, then enable: periods 10,10,11,10,11,...; cycles from tick 2 to tick 34 = 336.
3. div=16; pulse i_sync at counter=11: o_count=0 next cycle, no o_tick that cycle, o_half 8 enabled edges later, o_tick 16 edges later.
4. div=16; load div=4 at counter=5: current period still ends at 16 cycles, then ticks every 4 cycles; o_div_active changes only at the wrap edge.
5. Load div=0 then div=1: tick every 2 cycles, half on alternate edges. Drop i_en for 5 cycles mid-period: counter frozen, no pulses, period resumes with the remaining count.
6. Assert i_rst_n=0 asynchronously mid-period with div=10 frac=8: all outputs 0 immediately; after release, div 16 and frac 0 are restored.
